// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared types for the decode-stage issue controller: FSM state encoding
// and the hard-wired zero register number.
package decode_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    WAIT  = 2'd3
  } ctrl_state_e;

  localparam int unsigned X0 = 0;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Signal bundle between the decode stage and its issue controller.
// Handshake: the decode instruction transfers on the rising edge where in_valid and
// out_issue are both high; in_valid with out_issue low means the instruction must be held.
interface decode_hazard_ctrl_if #(
  parameter int REGISTERNO_WIDTH = 5,
  parameter int NUM_REGS         = 32
) ();
  import decode_ctrl_pkg::*;

  logic                        in_valid;
  logic [REGISTERNO_WIDTH-1:0] in_rs1_regno;
  logic [REGISTERNO_WIDTH-1:0] in_rs2_regno;
  logic [REGISTERNO_WIDTH-1:0] in_rd_regno;
  logic                        in_uses_rs1;
  logic                        in_uses_rs2;
  logic                        in_writes_rd;
  logic                        in_is_syscall;
  logic                        in_wb_enable;
  logic [REGISTERNO_WIDTH-1:0] in_wb_rd_regno;
  logic                        in_branch_taken_bool;
  logic                        in_syscall_done;

  logic                        out_issue;
  logic                        out_stall;
  logic                        out_advance;
  logic                        out_syscall_flush;
  logic                        out_syscall_req;
  logic [NUM_REGS-1:0]         out_busy_vec;
  ctrl_state_e                 state;

  modport master (
    output in_valid, in_rs1_regno, in_rs2_regno, in_rd_regno,
           in_uses_rs1, in_uses_rs2, in_writes_rd, in_is_syscall,
           in_wb_enable, in_wb_rd_regno, in_branch_taken_bool, in_syscall_done,
    input  out_issue, out_stall, out_advance, out_syscall_flush,
           out_syscall_req, out_busy_vec, state
  );

  modport slave (
    input  in_valid, in_rs1_regno, in_rs2_regno, in_rd_regno,
           in_uses_rs1, in_uses_rs2, in_writes_rd, in_is_syscall,
           in_wb_enable, in_wb_rd_regno, in_branch_taken_bool, in_syscall_done,
    output out_issue, out_stall, out_advance, out_syscall_flush,
           out_syscall_req, out_busy_vec, state
  );

endinterface

// File: rtl/decode_hazard_ctrl_reg_scoreboard.sv
// Per-register pending-writeback counters; flags RAW hazards and WAW counter
// saturation for the instruction currently in decode.
module reg_scoreboard
  import decode_ctrl_pkg::*;
#(
  parameter int REGISTERNO_WIDTH = 5,
  parameter int NUM_REGS         = 32,
  parameter int PEND_WIDTH       = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue,
  input  logic                        writes_rd,
  input  logic [REGISTERNO_WIDTH-1:0] rd_regno,
  input  logic                        uses_rs1,
  input  logic [REGISTERNO_WIDTH-1:0] rs1_regno,
  input  logic                        uses_rs2,
  input  logic [REGISTERNO_WIDTH-1:0] rs2_regno,
  input  logic                        wb_enable,
  input  logic [REGISTERNO_WIDTH-1:0] wb_rd_regno,
  output logic                        hazard,
  output logic [NUM_REGS-1:0]         busy_vec
);

  localparam logic [REGISTERNO_WIDTH-1:0] ZERO_REG = REGISTERNO_WIDTH'(X0);
  localparam logic [PEND_WIDTH-1:0]       PEND_MAX = '1;

  logic [PEND_WIDTH-1:0] pend [NUM_REGS];
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;

  // A writeback to an idle register is dropped rather than wrapping the counter.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue && writes_rd && rd_regno != ZERO_REG)
      inc_vec[rd_regno] = 1'b1;
    if (wb_enable && wb_rd_regno != ZERO_REG && pend[wb_rd_regno] != '0)
      dec_vec[wb_rd_regno] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          pend[i] <= pend[i] + PEND_WIDTH'(1);
        else if (dec_vec[i] && !inc_vec[i])
          pend[i] <= pend[i] - PEND_WIDTH'(1);
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) busy_vec[i] = (pend[i] != '0);
  end

  // Registered counters only: a writeback this cycle does not clear the hazard until next cycle.
  always_comb begin
    hazard = 1'b0;
    if (uses_rs1 && rs1_regno != ZERO_REG && pend[rs1_regno] != '0) hazard = 1'b1;
    if (uses_rs2 && rs2_regno != ZERO_REG && pend[rs2_regno] != '0) hazard = 1'b1;
    if (writes_rd && rd_regno != ZERO_REG && pend[rd_regno] == PEND_MAX) hazard = 1'b1;
  end

  wb_without_pending : assert property (@(posedge clk) disable iff (!reset)
    !(wb_enable && wb_rd_regno != ZERO_REG && pend[wb_rd_regno] == '0));

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage issue controller: scoreboard hazard stalls, taken-branch drop,
// and the syscall hold/drain/flush/handoff sequence.
module decode_hazard_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int REGISTERNO_WIDTH = 5,
  parameter int NUM_REGS         = 32,
  parameter int PEND_WIDTH       = 2,
  parameter int DRAIN_CYCLES     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_hazard_ctrl_if.slave  bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  ctrl_state_e   state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          flush_q;
  logic          hazard;
  logic          issue, resume, req;
  logic [NUM_REGS-1:0] busy_vec;

  reg_scoreboard #(
    .REGISTERNO_WIDTH (REGISTERNO_WIDTH),
    .NUM_REGS         (NUM_REGS),
    .PEND_WIDTH       (PEND_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue       (issue),
    .writes_rd   (bus.in_writes_rd),
    .rd_regno    (bus.in_rd_regno),
    .uses_rs1    (bus.in_uses_rs1),
    .rs1_regno   (bus.in_rs1_regno),
    .uses_rs2    (bus.in_uses_rs2),
    .rs2_regno   (bus.in_rs2_regno),
    .wb_enable   (bus.in_wb_enable),
    .wb_rd_regno (bus.in_wb_rd_regno),
    .hazard      (hazard),
    .busy_vec    (busy_vec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      drain_q <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      flush_q <= (state_d == FLUSH);
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    issue   = 1'b0;
    resume  = 1'b0;
    req     = 1'b0;
    case (state_q)
      RUN: begin
        issue = bus.in_valid && !hazard && !bus.in_is_syscall && !bus.in_branch_taken_bool;
        if (bus.in_valid && bus.in_is_syscall && !bus.in_branch_taken_bool) begin
          state_d = DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        // A taken branch here means the syscall was on the wrong path.
        if (bus.in_branch_taken_bool) begin
          state_d = RUN;
          drain_d = '0;
        end else if (drain_q == '0 && busy_vec == '0) begin
          state_d = FLUSH;
        end else if (drain_q != '0) begin
          drain_d = drain_q - DW'(1);
        end
      end
      FLUSH: state_d = WAIT;
      WAIT: begin
        req = 1'b1;
        if (bus.in_syscall_done) begin
          resume  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Input-driven outputs are forced low while reset is held.
  assign bus.out_issue         = reset & issue;
  assign bus.out_advance       = reset & (issue | resume);
  assign bus.out_stall         = reset & bus.in_valid & !issue & !bus.in_branch_taken_bool;
  assign bus.out_syscall_req   = req;
  assign bus.out_syscall_flush = flush_q;
  assign bus.out_busy_vec      = busy_vec;
  assign bus.state             = state_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: scoreboard hazards, counter saturation,
// syscall drain/flush/handoff, wrong-path syscall and asynchronous reset.
module tb_decode_hazard_ctrl;
  import decode_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   flush_seen = 0;

  decode_hazard_ctrl_if #(.REGISTERNO_WIDTH(5), .NUM_REGS(32)) bus ();

  decode_hazard_ctrl #(
    .REGISTERNO_WIDTH (5),
    .NUM_REGS         (32),
    .PEND_WIDTH       (2),
    .DRAIN_CYCLES     (4)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && bus.out_syscall_flush) flush_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_rs1_regno = 0; bus.in_rs2_regno = 0; bus.in_rd_regno = 0;
    bus.in_uses_rs1 = 0; bus.in_uses_rs2 = 0; bus.in_writes_rd = 0; bus.in_is_syscall = 0;
    bus.in_wb_enable = 0; bus.in_wb_rd_regno = 0; bus.in_branch_taken_bool = 0;
    bus.in_syscall_done = 0;
  endtask

  task automatic drive_write(input logic [4:0] rd);
    idle();
    bus.in_valid = 1; bus.in_writes_rd = 1; bus.in_rd_regno = rd;
  endtask

  task automatic drive_wb(input logic en, input logic [4:0] rd);
    bus.in_wb_enable = en; bus.in_wb_rd_regno = rd;
  endtask

  initial begin
    idle();
    rst_n = 0;
    drive_write(5'd5);
    #12;
    check("rst_issue",   32'(bus.out_issue), 32'd0);
    check("rst_stall",   32'(bus.out_stall), 32'd0);
    check("rst_advance", 32'(bus.out_advance), 32'd0);
    check("rst_busy",    bus.out_busy_vec, 32'd0);
    check("rst_req",     32'(bus.out_syscall_req), 32'd0);
    check("rst_flush",   32'(bus.out_syscall_flush), 32'd0);
    check("rst_state",   32'(bus.state), 32'(RUN));
    idle();
    tick();
    rst_n = 1;
    tick();

    // RAW on x5, cleared the cycle after the writeback
    drive_write(5'd5); #1;
    check("raw_issue_wr", 32'(bus.out_issue), 32'd1);
    check("raw_adv_wr",   32'(bus.out_advance), 32'd1);
    tick();
    idle(); bus.in_valid = 1; bus.in_uses_rs1 = 1; bus.in_rs1_regno = 5; #1;
    check("raw_stall",  32'(bus.out_stall), 32'd1);
    check("raw_noissue", 32'(bus.out_issue), 32'd0);
    check("raw_busy",   bus.out_busy_vec, 32'h0000_0020);
    tick(); #1;
    check("raw_stall2", 32'(bus.out_stall), 32'd1);
    tick();
    drive_wb(1, 5'd5); #1;
    check("raw_no_bypass", 32'(bus.out_stall), 32'd1);
    tick();
    drive_wb(0, 5'd0); #1;
    check("raw_release", 32'(bus.out_issue), 32'd1);
    check("raw_busy_clr", bus.out_busy_vec, 32'd0);
    tick();

    // WAW saturation on x7
    for (int k = 0; k < 3; k++) begin
      drive_write(5'd7); #1;
      check("waw_issue", 32'(bus.out_issue), 32'd1);
      tick();
    end
    #1;
    check("waw_full_stall", 32'(bus.out_stall), 32'd1);
    check("waw_busy", bus.out_busy_vec, 32'h0000_0080);
    drive_wb(1, 5'd7); #1;
    check("waw_full_wb_same", 32'(bus.out_stall), 32'd1);
    tick();
    drive_wb(0, 5'd0); #1;
    check("waw_after_wb", 32'(bus.out_issue), 32'd1);
    tick();
    idle();
    drive_wb(1, 5'd7);
    tick(); tick(); #1;
    check("waw_busy_2left", bus.out_busy_vec, 32'h0000_0080);
    tick();
    drive_wb(0, 5'd0); #1;
    check("waw_drained", bus.out_busy_vec, 32'd0);

    // Simultaneous increment and decrement of x3
    drive_write(5'd3); tick();
    drive_write(5'd3); drive_wb(1, 5'd3); #1;
    check("net_issue", 32'(bus.out_issue), 32'd1);
    tick();
    idle(); #1;
    check("net_busy", bus.out_busy_vec, 32'h0000_0008);
    drive_wb(1, 5'd3); tick();
    drive_wb(0, 5'd0); #1;
    check("net_one_left", bus.out_busy_vec, 32'd0);

    // Syscall with x9 pending; writeback arrives after the drain count expires
    drive_write(5'd9); tick();
    idle(); flush_seen = 0;
    bus.in_valid = 1; bus.in_is_syscall = 1; #1;
    check("sys_noissue", 32'(bus.out_issue), 32'd0);
    check("sys_noadv",   32'(bus.out_advance), 32'd0);
    check("sys_stall",   32'(bus.out_stall), 32'd1);
    tick();
    for (int k = 1; k <= 5; k++) begin
      check("sys_drain", 32'(bus.state), 32'(DRAIN));
      check("sys_drain_noflush", 32'(bus.out_syscall_flush), 32'd0);
      tick();
    end
    drive_wb(1, 5'd9); #1;
    check("sys_wait_busy", 32'(bus.state), 32'(DRAIN));
    tick();
    drive_wb(0, 5'd0); #1;
    check("sys_last_drain", 32'(bus.state), 32'(DRAIN));
    tick(); #1;
    check("sys_flush_state", 32'(bus.state), 32'(FLUSH));
    check("sys_flush", 32'(bus.out_syscall_flush), 32'd1);
    tick(); #1;
    check("sys_wait", 32'(bus.state), 32'(WAIT));
    check("sys_req", 32'(bus.out_syscall_req), 32'd1);
    check("sys_flush_off", 32'(bus.out_syscall_flush), 32'd0);
    check("sys_wait_noadv", 32'(bus.out_advance), 32'd0);
    tick();
    bus.in_valid = 0; bus.in_is_syscall = 0; bus.in_syscall_done = 1; #1;
    check("sys_done_adv", 32'(bus.out_advance), 32'd1);
    tick();
    bus.in_syscall_done = 0; #1;
    check("sys_resume_state", 32'(bus.state), 32'(RUN));
    check("sys_resume_req", 32'(bus.out_syscall_req), 32'd0);
    check("sys_adv_pulse", 32'(bus.out_advance), 32'd0);
    check("sys_one_flush", 32'(flush_seen), 32'd1);

    // Wrong-path syscall cancelled by a taken branch during DRAIN
    flush_seen = 0;
    bus.in_valid = 1; bus.in_is_syscall = 1;
    tick(); tick();
    bus.in_branch_taken_bool = 1; #1;
    check("wp_noadv", 32'(bus.out_advance), 32'd0);
    check("wp_nostall", 32'(bus.out_stall), 32'd0);
    tick();
    idle(); #1;
    check("wp_run", 32'(bus.state), 32'(RUN));
    for (int k = 0; k < 6; k++) tick();
    check("wp_no_flush", 32'(flush_seen), 32'd0);
    check("wp_still_run", 32'(bus.state), 32'(RUN));

    // Exact latency with nothing pending, then reset during WAIT
    bus.in_valid = 1; bus.in_is_syscall = 1; #1;
    tick();
    idle();
    for (int k = 1; k <= 5; k++) begin
      check("lat_drain", 32'(bus.state), 32'(DRAIN));
      tick();
    end
    check("lat_flush", 32'(bus.state), 32'(FLUSH));
    tick();
    check("lat_wait", 32'(bus.state), 32'(WAIT));
    drive_write(5'd4); #1;
    check("lat_req", 32'(bus.out_syscall_req), 32'd1);
    rst_n = 0; #1;
    check("rw_req", 32'(bus.out_syscall_req), 32'd0);
    check("rw_state", 32'(bus.state), 32'(RUN));
    check("rw_issue", 32'(bus.out_issue), 32'd0);
    check("rw_stall", 32'(bus.out_stall), 32'd0);
    check("rw_busy", bus.out_busy_vec, 32'd0);
    tick();
    idle(); rst_n = 1;
    tick(); #1;
    check("rw_after_state", 32'(bus.state), 32'(RUN));
    check("rw_after_req", 32'(bus.out_syscall_req), 32'd0);

    // Reset clears a pending counter
    drive_write(5'd12); tick();
    idle(); #1;
    check("rp_busy", bus.out_busy_vec, 32'h0000_1000);
    rst_n = 0; #1;
    check("rp_cleared", bus.out_busy_vec, 32'd0);
    tick();
    rst_n = 1;
    tick(); #1;
    bus.in_valid = 1; bus.in_uses_rs2 = 1; bus.in_rs2_regno = 12; #1;
    check("rp_no_hazard", 32'(bus.out_issue), 32'd1);
    tick();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_hazard_ctrl.md
# decode_hazard_ctrl

Issue controller for the decode stage. It tracks registers with pending writebacks in a scoreboard, stalls decode on read-after-write and write-after-write hazards, and drops the decode-stage instruction when a branch is taken. It also runs the syscall drain sequence: hold, drain the pipeline, flush, hand off to the handler, resume. It sits beside the decode stage; it drives that stage's enable and syscall-flush inputs and observes the writeback port.

## Interface
- REGISTERNO_WIDTH, 5, register-number width
- NUM_REGS, 32, architectural registers (x0 never tracked)
- PEND_WIDTH, 2, per-register pending-write counter width (max 3 outstanding)
- DRAIN_CYCLES, 4, cycles for non-writing instructions to leave the pipe
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- in_valid  in  1  decode holds an instruction
- in_rs1_regno / in_rs2_regno / in_rd_regno  in  REGISTERNO_WIDTH  operands of decode instruction
- in_uses_rs1 / in_uses_rs2 / in_writes_rd  in  1  operand-use flags
- in_is_syscall  in  1  decode instruction is ecall
- in_wb_enable  in  1  writeback retiring
- in_wb_rd_regno  in  REGISTERNO_WIDTH  writeback destination
- in_branch_taken_bool  in  1  branch resolved taken this cycle
- in_syscall_done  in  1  handler finished (level)
- out_issue  out  1  decode enable; instruction advances this edge
- out_stall  out  1  in_valid & !out_issue & !in_branch_taken_bool
- out_advance  out  1  fetch may present next instruction (out_issue, or syscall consumed)
- out_syscall_flush  out  1  registered one-cycle flush pulse
- out_syscall_req  out  1  handler request, level in WAIT
- out_busy_vec  out  NUM_REGS  bit i = register i has pending write

## Operation
- Scoreboard: per-register counter pend[i], PEND_WIDTH bits.
- Issue with in_writes_rd & rd≠0 increments pend[rd].
- in_wb_enable & wb_rd≠0 decrements pend[wb_rd].
- Same register, same cycle, increment and decrement: net unchanged.
- Decrement at 0 is ignored; flag with assertion.
- hazard = (uses_rs1 & pend[rs1]≠0) | (uses_rs2 & pend[rs2]≠0) | (writes_rd & pend[rd]==max). Register 0 is never hazardous.
- Hazard uses registered counters only; no same-cycle writeback bypass.
- States: RUN, DRAIN, FLUSH, WAIT.
- RUN: out_issue = in_valid & !hazard & !in_is_syscall & !in_branch_taken_bool.
- RUN → DRAIN: in_valid & in_is_syscall & !in_branch_taken_bool. The syscall is not issued; drain_cnt loads DRAIN_CYCLES.
- DRAIN: drain_cnt decrements to 0. Moves to FLUSH when drain_cnt==0 and out_busy_vec==0.
- DRAIN with in_branch_taken_bool: wrong-path syscall; return to RUN, no flush, no advance.
- FLUSH: out_syscall_flush=1 for exactly one cycle, then WAIT.
- WAIT: out_syscall_req=1. On in_syscall_done, out_advance pulses one cycle, then RUN.
- Branch taken in RUN: out_issue=0, out_advance=0; scoreboard unchanged.
- Reset mid-sequence: immediately RUN, counters 0, all outputs 0.

## Timing
- Reset values: state RUN, pend all 0, drain_cnt 0, all outputs 0.
- out_issue, out_stall, out_advance, out_busy_vec, out_syscall_req: combinational from registered state plus current inputs.
- out_syscall_flush: registered.
- Writeback in cycle N clears a RAW stall in cycle N+1.
- Syscall latency, no pending writes: detect at N; DRAIN N+1..N+DRAIN_CYCLES+1; FLUSH at N+DRAIN_CYCLES+2; WAIT from the next cycle.
- in_syscall_done already high on entry to WAIT: leave after one WAIT cycle.

## Structure
- Package decode_ctrl_pkg holds the state enum (RUN/DRAIN/FLUSH/WAIT) and the x0 constant.
- Sub-module reg_scoreboard: counters, busy vector, hazard inputs/outputs.
- The FSM lives in decode_hazard_ctrl.

## Test plan
- Issue add x5 (writes_rd); next cycle read x5 → stall. Writeback x5 at cycle 4 → issue at cycle 5.
- Three issues writing x7 without writeback → pend[7]=3. Fourth write to x7 stalls until one writeback.
- Issue writing x3 and writeback of x3 on the same edge, pend[3]=1 before → pend[3] stays 1.
- Syscall with pend[9]=1, writeback at cycle 6, DRAIN_CYCLES=4 → flush pulse exactly once after the writeback. Then req high; done → advance pulse, state RUN.
- Syscall in DRAIN, then branch taken → RUN, no flush pulse, no advance.
- Reset low during WAIT → req drops immediately, busy_vec 0, state RUN after release.
